// File: rtl/maxnet_pkg.sv
// Shared types and helpers for the fixed-point Maxnet winner-take-all core.
// Holds the FSM state enum, the result bundle and saturate/relu helpers.
package maxnet_pkg;

  localparam int VAL_MAXW = 32;
  localparam int IDX_MAXW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_UPDATE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic                winner_valid;
    logic                timeout;
    logic                overflow;
    logic [IDX_MAXW-1:0] idx;
    logic [VAL_MAXW-1:0] value;
  } res_t;

  typedef struct packed {
    logic               ovf;
    logic signed [63:0] val;
  } sat_t;

  // a+b clamped to a signed w-bit range
  function automatic sat_t sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t               r;
    s     = a + b;
    hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.ovf = 1'b0;
    r.val = s;
    if (s > hi) begin
      r.ovf = 1'b1;
      r.val = hi;
    end else if (s < lo) begin
      r.ovf = 1'b1;
      r.val = lo;
    end
    return r;
  endfunction

  function automatic logic signed [63:0] relu(
    input logic signed [63:0] x
  );
    return x[63] ? 64'sd0 : x;
  endfunction

endpackage

// File: rtl/maxnet_mac.sv
// Combinational Maxnet update: v = relu(sat(a + ((eps*(S-a)) >>> FRAC))).
// Ports: a_i, eps_i, s_i in; v_o, ovf_o out. MAXNET_ROUND_EN: round half up.
module maxnet_mac
  import maxnet_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int SW    = 19
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] eps_i,
  input  logic signed [SW-1:0]    s_i,
  output logic signed [WIDTH-1:0] v_o,
  output logic                    ovf_o
);

  localparam int DW = SW + 1;
  localparam int PW = WIDTH + DW + 1;

  logic signed [DW-1:0] d;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] pr;
  logic signed [PW-1:0] p;
  sat_t                 sr;
  logic signed [63:0]   r;

  always_comb begin
    d    = DW'(s_i) - DW'(a_i);
    prod = PW'(eps_i) * PW'(d);
`ifdef MAXNET_ROUND_EN
    pr   = prod + (PW'(1) <<< (FRAC - 1));
`else
    pr   = prod;
`endif
    p     = pr >>> FRAC;
    sr    = sat_add(64'(a_i), 64'(p), WIDTH);
    r     = relu($signed(sr.val));
    v_o   = WIDTH'(r);
    ovf_o = sr.ovf;
  end

endmodule

// File: rtl/maxnet_fx.sv
// Fixed-point Maxnet: serial load, one MAC iterating until one winner/limit.
// Ports: clk,rst,start,eps,in_* in; busy,finish,flags,winner_*,out out. MAXNET_ROUND_EN.
module maxnet_fx
  import maxnet_pkg::*;
#(
  parameter int N        = 4,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 12,
  parameter int MAX_ITER = 64,
  localparam int IDXW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] eps,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             busy,
  output logic             finish,
  output logic             overflow,
  output logic             timeout,
  output logic             winner_valid,
  output logic [IDXW-1:0]  winner_idx,
  output logic [WIDTH-1:0] out
);

  localparam int SW  = WIDTH + IDXW + 1;
  localparam int CW  = IDXW + 1;
  localparam int ITW = $clog2(MAX_ITER + 1);

  state_e state_q, state_d;
  res_t   res_q, res_d;
  logic   fin_q, fin_d;

  logic signed [WIDTH-1:0] eps_q, eps_d;
  logic signed [SW-1:0]    sum_q, sum_d;
  logic signed [SW-1:0]    s_q, s_d;
  logic [CW-1:0]           pos_q, pos_d;
  logic [IDXW-1:0]         k_q, k_d;
  logic [IDXW-1:0]         widx_q, widx_d;
  logic [ITW-1:0]          it_q, it_d;

  logic signed [WIDTH-1:0] a_q [N];
  logic signed [WIDTH-1:0] din;
  logic signed [WIDTH-1:0] wdata;
  logic signed [WIDTH-1:0] v_new;
  logic                    ovf_new;
  logic                    we;
  logic                    wpos;
  logic                    last;

  assign din = in_data;

  maxnet_mac #(
    .WIDTH(WIDTH),
    .FRAC (FRAC),
    .SW   (SW)
  ) u_mac (
    .a_i  (a_q[k_q]),
    .eps_i(eps_q),
    .s_i  (s_q),
    .v_o  (v_new),
    .ovf_o(ovf_new)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    fin_d   = 1'b0;
    eps_d   = eps_q;
    sum_d   = sum_q;
    s_d     = s_q;
    pos_d   = pos_q;
    k_d     = k_q;
    widx_d  = widx_q;
    it_d    = it_q;
    we      = 1'b0;
    wdata   = v_new;
    last    = (k_q == IDXW'(N - 1));
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          eps_d   = eps;
          res_d   = '0;
          it_d    = '0;
          sum_d   = '0;
          pos_d   = '0;
          k_d     = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          we    = 1'b1;
          wdata = din;
          k_d   = last ? '0 : k_q + IDXW'(1);
          if (last) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (pos_q == CW'(1)) begin
          state_d            = S_DONE;
          res_d.winner_valid = 1'b1;
        end else if (pos_q == '0) begin
          state_d = S_DONE;
        end else if (it_q == ITW'(MAX_ITER)) begin
          state_d       = S_DONE;
          res_d.timeout = 1'b1;
        end else begin
          state_d = S_UPDATE;
          s_d     = sum_q;
          sum_d   = '0;
          pos_d   = '0;
          k_d     = '0;
        end
      end
      S_UPDATE: begin
        we = 1'b1;
        if (ovf_new) res_d.overflow = 1'b1;
        k_d = last ? '0 : k_q + IDXW'(1);
        if (last) begin
          state_d = S_CHECK;
          it_d    = it_q + ITW'(1);
        end
      end
      S_DONE: begin
        fin_d   = 1'b1;
        state_d = S_IDLE;
        if (res_q.winner_valid) begin
          res_d.idx   = IDX_MAXW'(widx_q);
          res_d.value = VAL_MAXW'(a_q[widx_q]);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // every written value feeds the next CHECK; the last positive
    // index seen is the winner when exactly one survives
    wpos = we && !wdata[WIDTH-1] && (wdata != '0);
    if (we) sum_d = sum_q + SW'(wdata);
    if (wpos) begin
      pos_d  = pos_q + CW'(1);
      widx_d = k_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      fin_q   <= 1'b0;
      eps_q   <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      pos_q   <= '0;
      k_q     <= '0;
      widx_q  <= '0;
      it_q    <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      fin_q   <= fin_d;
      eps_q   <= eps_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      pos_q   <= pos_d;
      k_q     <= k_d;
      widx_q  <= widx_d;
      it_q    <= it_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) a_q[k_q] <= wdata;
  end

  assign in_ready     = (state_q == S_LOAD);
  assign busy         = (state_q != S_IDLE);
  assign finish       = fin_q;
  assign overflow     = res_q.overflow;
  assign timeout      = res_q.timeout;
  assign winner_valid = res_q.winner_valid;
  assign winner_idx   = IDXW'(res_q.idx);
  assign out          = WIDTH'(res_q.value);

endmodule

// File: tb/tb_maxnet_fx.sv
// Directed self-checking bench for maxnet_fx (default and MAX_ITER=4).
// Expected results are hand-computed Q4.12 integer traces.
module tb_maxnet_fx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        start_s = 1'b0;
  logic        vld_s = 1'b0;
  logic [15:0] eps_s = '0;
  logic [15:0] din = '0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic        ir0, bz0, fn0, ov0, to0, wv0;
  logic [1:0]  ix0;
  logic [15:0] o0;
  logic        ir1, bz1, fn1, ov1, to1, wv1;
  logic [1:0]  ix1;
  logic [15:0] o1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maxnet_fx dut (
    .clk(clk), .rst(rst), .start(start_s & ~sel), .eps(eps_s),
    .in_data(din), .in_valid(vld_s & ~sel), .in_ready(ir0),
    .busy(bz0), .finish(fn0), .overflow(ov0), .timeout(to0),
    .winner_valid(wv0), .winner_idx(ix0), .out(o0)
  );

  maxnet_fx #(.MAX_ITER(4)) dut_t (
    .clk(clk), .rst(rst), .start(start_s & sel), .eps(eps_s),
    .in_data(din), .in_valid(vld_s & sel), .in_ready(ir1),
    .busy(bz1), .finish(fn1), .overflow(ov1), .timeout(to1),
    .winner_valid(wv1), .winner_idx(ix1), .out(o1)
  );

  wire        ir = sel ? ir1 : ir0;
  wire        bz = sel ? bz1 : bz0;
  wire        fn = sel ? fn1 : fn0;
  wire        ov = sel ? ov1 : ov0;
  wire        to = sel ? to1 : to0;
  wire        wv = sel ? wv1 : wv0;
  wire [1:0]  ix = sel ? ix1 : ix0;
  wire [15:0] ov_out = sel ? o1 : o0;

  task automatic check(input string tag, input longint got,
                       input longint exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic run(input logic [15:0] e, input logic [63:0] vec,
                     input bit gaps, input bit spam, output int lat);
    int h;
    eps_s   = e;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    check("in_ready", ir, 1);
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          vld_s   = 1'b0;
          start_s = spam;
          eps_s   = spam ? 16'h1234 : e;
          @(posedge clk); #1;
        end
        start_s = 1'b0;
        eps_s   = e;
      end
      vld_s = 1'b1;
      din   = vec[16*k +: 16];
      @(posedge clk); #1;
      vld_s = 1'b0;
    end
    h   = cyc;
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      start_s = spam;
      @(posedge clk); #1;
      if (fn) begin
        lat = cyc - h;
        break;
      end
    end
    start_s = 1'b0;
    if (lat < 0) check("finish_wait", 0, 1);
  endtask

  int lat;
  int nfin;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bz0, 0);
    check("rst_ready", ir0, 0);
    check("rst_outs", {fn0, ov0, to0, wv0, ix0, o0}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single positive: immediate winner
    run(16'hFCCD, {16'hFFFF, 16'd1000, 16'hFFFB, 16'hFF9C}, 0, 0, lat);
    check("r1_lat", lat, 2);
    check("r1_wv", wv, 1);
    check("r1_idx", ix, 2);
    check("r1_out", ov_out, 1000);
    check("r1_to", to, 0);

    // five iterations, winner ch3 = 1723
    run(16'hFCCD, {16'd3277, 16'd2458, 16'd1638, 16'd819}, 0, 0, lat);
    check("r2_lat", lat, 27);
    check("r2_wv", wv, 1);
    check("r2_idx", ix, 3);
    check("r2_out", ov_out, 1723);
    check("r2_ovf", ov, 0);
    check("r2_to", to, 0);

    // all zero: no winner, one CHECK
    run(16'hFCCD, 64'd0, 0, 0, lat);
    check("z_lat", lat, 2);
    check("z_wv", wv, 0);
    check("z_out", ov_out, 0);

    // iteration limit of 4 with a symmetric pair
    sel = 1'b1;
    run(16'hFCCD, {16'd0, 16'd0, 16'd1000, 16'd1000}, 0, 0, lat);
    check("t_lat", lat, 22);
    check("t_to", to, 1);
    check("t_wv", wv, 0);
    check("t_out", ov_out, 0);
    sel = 1'b0;

    // saturation: every channel clamps to 0
    run(16'h8000, {4{16'h7FFF}}, 0, 0, lat);
    check("o_lat", lat, 7);
    check("o_ovf", ov, 1);
    check("o_wv", wv, 0);
    check("o_out", ov_out, 0);
    run(16'hFCCD, {16'hFFFF, 16'd1000, 16'hFFFB, 16'hFF9C}, 0, 0, lat);
    check("o2_ovf", ov, 0);
    check("o2_out", ov_out, 1000);

    // stalls and ignored start pulses while busy
    run(16'hFCCD, {16'd3277, 16'd2458, 16'd1638, 16'd819}, 1, 1, lat);
    check("g_lat", lat, 27);
    check("g_idx", ix, 3);
    check("g_out", ov_out, 1723);
    check("g_busy", bz, 0);

    // reset in the middle of UPDATE
    eps_s   = 16'hFCCD;
    start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vld_s = 1'b1;
      din   = 16'd819 * 16'(k + 1);
      @(posedge clk); #1;
    end
    vld_s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rr_busy", bz0, 0);
    check("rr_outs", {fn0, ov0, to0, wv0, ix0, o0}, 0);
    rst  = 1'b0;
    nfin = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (fn0) nfin++;
    end
    check("rr_nofin", nfin, 0);
    run(16'hFCCD, {16'hFFFF, 16'd1000, 16'hFFFB, 16'hFF9C}, 0, 0, lat);
    check("rr_lat", lat, 2);
    check("rr_idx", ix, 2);
    check("rr_out", ov_out, 1000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
